// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush controller for the five-stage MIPS pipeline.
// Handles load-use bubbles, taken-branch squashes, memory wait states and
// halt, and keeps saturating performance counters for stall activity.
module hazard_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        exm_dREN,
    input  logic        exm_dWEN,
    input  logic        exm_halt,
    input  logic        idex_dREN,
    input  logic [4:0]  idex_wsel,
    input  logic        idex_pc_src,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        ifid_uses_rt,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exm_en,
    output logic        mwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        mwb_flush,
    output logic        dreq_mask,
    output logic        dload_capture,
    output logic        halted,
    output logic [31:0] stall_cycles,
    output logic [31:0] lu_stalls,
    output logic [31:0] br_squashes
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HALT = 1'b1;

    logic [0:0] state;
    logic       mem_done;

    logic in_run;
    logic dreq_live;
    logic mem_ok;
    logic adv;
    logic lu;
    logic lu_bubble;
    logic br_squash;

    // Saturating increment so counters stick at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

    // Pipeline advance condition and load-use detection
    always_comb begin
        in_run    = (state == RUN);
        dreq_live = (exm_dREN | exm_dWEN) & ~mem_done;
        mem_ok    = ~dreq_live | dhit;
        adv       = in_run & ihit & mem_ok;
        lu        = idex_dREN & (idex_wsel != 5'd0) &
                    ((idex_wsel == ifid_rs) | (ifid_uses_rt & (idex_wsel == ifid_rt)));
        br_squash = adv & idex_pc_src;
        lu_bubble = adv & lu & ~idex_pc_src;
    end

    // Mealy enable/flush/mask outputs; a taken branch outranks a load-use stall
    always_comb begin
        pc_en         = 1'b0;
        ifid_en       = 1'b0;
        idex_en       = 1'b0;
        exm_en        = 1'b0;
        mwb_en        = 1'b0;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        mwb_flush     = 1'b0;
        dreq_mask     = 1'b0;
        dload_capture = 1'b0;
        if (RST) begin
            dreq_mask = 1'b0;
        end else if (state == HALT) begin
            dreq_mask = 1'b1;
        end else begin
            dreq_mask     = mem_done;
            dload_capture = dhit & dreq_live;
            if (adv) begin
                idex_en = 1'b1;
                exm_en  = 1'b1;
                mwb_en  = 1'b1;
                if (idex_pc_src) begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (lu) begin
                    idex_flush = 1'b1;
                end else begin
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                end
            end
        end
    end

    // State, completed-access flag, halt indication and performance counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= RUN;
            mem_done     <= 1'b0;
            halted       <= 1'b0;
            stall_cycles <= 32'd0;
            lu_stalls    <= 32'd0;
            br_squashes  <= 32'd0;
        end else if (in_run) begin
            if (adv) begin
                mem_done <= 1'b0;
            end else if (dhit & dreq_live) begin
                mem_done <= 1'b1;
            end
            if (adv & exm_halt) begin
                state  <= HALT;
                halted <= 1'b1;
            end
            if (!adv) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
            if (lu_bubble) begin
                lu_stalls <= sat_inc(lu_stalls);
            end
            if (br_squash) begin
                br_squashes <= sat_inc(br_squashes);
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: scoreboard bench for hazard_unit. Each cycle the expected
// outputs are computed from an independent behavioural model, queued, and
// compared against the DUT shortly before the next rising edge.
module tb_hazard_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, dhit;
    logic        exm_dREN, exm_dWEN, exm_halt;
    logic        idex_dREN;
    logic [4:0]  idex_wsel;
    logic        idex_pc_src;
    logic [4:0]  ifid_rs, ifid_rt;
    logic        ifid_uses_rt;
    logic        pc_en, ifid_en, idex_en, exm_en, mwb_en;
    logic        ifid_flush, idex_flush, mwb_flush;
    logic        dreq_mask, dload_capture, halted;
    logic [31:0] stall_cycles, lu_stalls, br_squashes;

    typedef struct packed {
        logic [4:0]  enables;
        logic [2:0]  flushes;
        logic        dreq_mask;
        logic        dload_capture;
        logic        halted;
        logic [31:0] stall_cycles;
        logic [31:0] lu_stalls;
        logic [31:0] br_squashes;
    } expect_t;

    expect_t scoreboard[$];

    int num_checks = 0;
    int num_fails  = 0;

    logic        m_halt;
    logic        m_mem_done;
    logic        m_halted;
    logic [31:0] m_stall, m_lu, m_br;

    hazard_unit dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .exm_dREN(exm_dREN), .exm_dWEN(exm_dWEN), .exm_halt(exm_halt),
        .idex_dREN(idex_dREN), .idex_wsel(idex_wsel), .idex_pc_src(idex_pc_src),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exm_en(exm_en),
        .mwb_en(mwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .mwb_flush(mwb_flush), .dreq_mask(dreq_mask), .dload_capture(dload_capture),
        .halted(halted), .stall_cycles(stall_cycles), .lu_stalls(lu_stalls),
        .br_squashes(br_squashes)
    );

    // Free-running core clock
    always #5 CLK = ~CLK;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Model's view of this cycle's outputs, derived from the current inputs
    function automatic expect_t modelOutputs();
        expect_t e;
        logic busy, memready, go, hazard;
        busy     = (exm_dREN || exm_dWEN) && !m_mem_done;
        memready = !busy || dhit;
        go       = !RST && !m_halt && ihit && memready;
        hazard   = idex_dREN && (idex_wsel != 5'd0) &&
                   (idex_wsel == ifid_rs || (ifid_uses_rt && idex_wsel == ifid_rt));
        e.enables = {go && (idex_pc_src || !hazard), go && (idex_pc_src || !hazard), go, go, go};
        e.flushes = {go && idex_pc_src, go && (idex_pc_src || hazard), 1'b0};
        e.dreq_mask     = RST ? 1'b0 : (m_halt ? 1'b1 : m_mem_done);
        e.dload_capture = !RST && !m_halt && dhit && busy;
        e.halted        = m_halted;
        e.stall_cycles  = m_stall;
        e.lu_stalls     = m_lu;
        e.br_squashes   = m_br;
        return e;
    endfunction

    // Model state update on the clock edge, using the inputs held this cycle
    task automatic advanceModel();
        logic busy, memready, go, hazard;
        busy     = (exm_dREN || exm_dWEN) && !m_mem_done;
        memready = !busy || dhit;
        go       = !m_halt && ihit && memready;
        hazard   = idex_dREN && (idex_wsel != 5'd0) &&
                   (idex_wsel == ifid_rs || (ifid_uses_rt && idex_wsel == ifid_rt));
        if (RST) begin
            m_halt = 1'b0; m_mem_done = 1'b0; m_halted = 1'b0;
            m_stall = 32'd0; m_lu = 32'd0; m_br = 32'd0;
        end else if (!m_halt) begin
            if (!go && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
            if (go && hazard && !idex_pc_src && m_lu != 32'hFFFF_FFFF) m_lu = m_lu + 32'd1;
            if (go && idex_pc_src && m_br != 32'hFFFF_FFFF) m_br = m_br + 32'd1;
            if (go) m_mem_done = 1'b0;
            else if (dhit && busy) m_mem_done = 1'b1;
            if (go && exm_halt) begin
                m_halt = 1'b1; m_halted = 1'b1;
            end
        end
    endtask

    // One cycle: queue expectation, compare before the edge, then clock
    task automatic applyStimulus();
        expect_t e;
        scoreboard.push_back(modelOutputs());
        #2;
        e = scoreboard.pop_front();
        checkOutput("pc_en",         {31'd0, pc_en},         {31'd0, e.enables[4]});
        checkOutput("ifid_en",       {31'd0, ifid_en},       {31'd0, e.enables[3]});
        checkOutput("idex_en",       {31'd0, idex_en},       {31'd0, e.enables[2]});
        checkOutput("exm_en",        {31'd0, exm_en},        {31'd0, e.enables[1]});
        checkOutput("mwb_en",        {31'd0, mwb_en},        {31'd0, e.enables[0]});
        checkOutput("ifid_flush",    {31'd0, ifid_flush},    {31'd0, e.flushes[2]});
        checkOutput("idex_flush",    {31'd0, idex_flush},    {31'd0, e.flushes[1]});
        checkOutput("mwb_flush",     {31'd0, mwb_flush},     {31'd0, e.flushes[0]});
        checkOutput("dreq_mask",     {31'd0, dreq_mask},     {31'd0, e.dreq_mask});
        checkOutput("dload_capture", {31'd0, dload_capture}, {31'd0, e.dload_capture});
        checkOutput("halted",        {31'd0, halted},        {31'd0, e.halted});
        checkOutput("stall_cycles",  stall_cycles,           e.stall_cycles);
        checkOutput("lu_stalls",     lu_stalls,              e.lu_stalls);
        checkOutput("br_squashes",   br_squashes,            e.br_squashes);
        @(posedge CLK);
        advanceModel();
        @(negedge CLK);
    endtask

    task automatic idleInputs();
        RST = 1'b0; ihit = 1'b1; dhit = 1'b0;
        exm_dREN = 1'b0; exm_dWEN = 1'b0; exm_halt = 1'b0;
        idex_dREN = 1'b0; idex_wsel = 5'd0; idex_pc_src = 1'b0;
        ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b0;
    endtask

    initial begin
        idleInputs();
        RST = 1'b1;
        m_halt = 1'b0; m_mem_done = 1'b0; m_halted = 1'b0;
        m_stall = 32'd0; m_lu = 32'd0; m_br = 32'd0;
        @(posedge CLK);
        @(negedge CLK);

        $display("[TB] reset behaviour");
        applyStimulus();
        RST = 1'b0;
        applyStimulus();

        $display("[TB] load-use stall");
        idex_dREN = 1'b1; idex_wsel = 5'd8; ifid_rs = 5'd8;
        applyStimulus();
        idex_dREN = 1'b0;
        applyStimulus();

        $display("[TB] no-stall cases");
        idex_dREN = 1'b1; idex_wsel = 5'd0; ifid_rs = 5'd0;
        applyStimulus();
        idex_wsel = 5'd8; ifid_rs = 5'd3; ifid_rt = 5'd8; ifid_uses_rt = 1'b0;
        applyStimulus();
        ifid_uses_rt = 1'b1;
        applyStimulus();
        idleInputs();
        applyStimulus();

        $display("[TB] taken branch with load-use");
        idex_dREN = 1'b1; idex_wsel = 5'd8; ifid_rs = 5'd8; idex_pc_src = 1'b1;
        applyStimulus();
        idleInputs();
        applyStimulus();

        $display("[TB] memory wait");
        exm_dREN = 1'b1; dhit = 1'b0; ihit = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus();
        dhit = 1'b1; ihit = 1'b0;
        applyStimulus();
        dhit = 1'b0;
        for (int i = 0; i < 2; i++) applyStimulus();
        ihit = 1'b1;
        applyStimulus();
        idleInputs();
        applyStimulus();

        $display("[TB] simultaneous ihit and dhit");
        exm_dWEN = 1'b1; dhit = 1'b1;
        applyStimulus();
        idleInputs();
        applyStimulus();

        $display("[TB] counter saturation");
        force dut.stall_cycles = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cycles;
        m_stall = 32'hFFFF_FFFE;
        ihit = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus();
        ihit = 1'b1;
        applyStimulus();

        $display("[TB] halt");
        exm_halt = 1'b1;
        applyStimulus();
        exm_halt = 1'b0; dhit = 1'b1; exm_dREN = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus();
        idleInputs();
        RST = 1'b1;
        applyStimulus();
        RST = 1'b0;
        applyStimulus();
        applyStimulus();

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard and stall controller for the five-stage MIPS core. It produces the enable and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latches. It handles the cases the forwarding unit cannot: load-use dependences, taken branches and jumps, instruction/data memory wait states, and halt. It also maintains saturating performance counters for stall cycles, load-use bubbles and branch squashes.

## Interface
- No parameters; counter width fixed at 32.
- CLK  in  1  core clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- ihit  in  1  instruction fetch completes this cycle
- dhit  in  1  data access completes this cycle
- exm_dREN  in  1  instruction in MEM is a load
- exm_dWEN  in  1  instruction in MEM is a store
- exm_halt  in  1  instruction in MEM is HALT
- idex_dREN  in  1  instruction in EX is a load
- idex_wsel  in  5  destination register of instruction in EX
- idex_pc_src  in  1  taken branch or jump resolved in EX
- ifid_rs  in  5  rs of instruction in ID
- ifid_rt  in  5  rt of instruction in ID
- ifid_uses_rt  in  1  ID instruction reads rt as a source
- pc_en, ifid_en, idex_en, exm_en, mwb_en  out  1 each  latch/PC load enables
- ifid_flush, idex_flush, mwb_flush  out  1 each  load a bubble into that latch (only acts when its enable is 1)
- dreq_mask  out  1  MEM stage must suppress dREN/dWEN
- dload_capture  out  1  MEM stage captures dload into its hold register
- halted  out  1  sticky halt indication
- stall_cycles, lu_stalls, br_squashes  out  32 each  saturating counters

## Operation
- State: FSM {RUN, HALT}, flag mem_done, three counters.
- Derived signals:
  - dreq_live = (exm_dREN | exm_dWEN) & ~mem_done
  - mem_ok = ~dreq_live | dhit
  - adv = (state==RUN) & ihit & mem_ok
  - lu = idex_dREN & (idex_wsel!=0) & ((idex_wsel==ifid_rs) | (ifid_uses_rt & idex_wsel==ifid_rt))
- dreq_mask = mem_done. dload_capture = dhit & dreq_live.
- RUN, adv=0: all five enables 0, all flushes 0. The whole pipeline freezes.
- RUN, adv=1, no hazard: all enables 1, all flushes 0.
- RUN, adv=1, idex_pc_src=1:
  - all enables 1
  - ifid_flush=1, idex_flush=1 (squash the two younger instructions)
  - branch takes priority over lu
- RUN, adv=1, lu=1, idex_pc_src=0:
  - pc_en=0, ifid_en=0 (hold fetch and decode)
  - idex_en=1 with idex_flush=1 (bubble into EX)
  - exm_en=1, mwb_en=1
- mem_done:
  - Set when dhit & dreq_live & ~adv, i.e. data finished while fetch is still waiting.
  - Cleared on any cycle with adv=1.
  - While set, the access is not reissued; the MEM stage's hold register supplies the load data.
- RUN→HALT: on adv=1 with exm_halt=1.
- HALT:
  - all enables 0, halted=1, dreq_mask=1
  - stays until RST; inputs are ignored
- Counters:
  - stall_cycles increments each RUN cycle with adv=0.
  - lu_stalls increments on each lu bubble inserted.
  - br_squashes increments on each adv with idex_pc_src.
  - All three saturate at 0xFFFFFFFF.

## Timing
- All enable, flush, mask and capture outputs are combinational from current inputs and state (Mealy), with zero latency.
- halted and the counters are registered.
- While RST=1: all enables 0, all flushes 0, dreq_mask=0, dload_capture=0.
- Next edge with RST=1: state=RUN, mem_done=0, halted=0, counters=0. Reset asserted mid-stall or in HALT takes effect the same way.
- A load-use bubble lasts exactly one advancing cycle. Memory waits before that cycle extend it but do not insert a second bubble.
- ihit & dhit in the same cycle: adv=1, mem_done stays 0, and no dload_capture latching is required beyond that cycle.
- A load followed by a dependent ALU op costs exactly one bubble. Forwarding supplies the value afterward.

## Test plan
- Load-use stall:
  - Stimulus: ihit=1 constant, idex_dREN=1, idex_wsel=8, ifid_rs=8, for one cycle.
  - Required: pc_en=0, ifid_en=0, idex_flush=1, lu_stalls 0→1.
  - Next cycle with idex_dREN=0: all enables 1.
- No stall cases:
  - Same as load-use but idex_wsel=0 → no stall.
  - Same as load-use but ifid_rt=8, ifid_uses_rt=0, ifid_rs≠8 → no stall.
- Taken branch with simultaneous lu:
  - Stimulus: idex_pc_src=1 and lu=1 in the same cycle.
  - Required: all enables 1, ifid_flush=1, idex_flush=1, br_squashes=1, lu_stalls unchanged.
- Memory wait:
  - Stimulus: exm_dREN=1, dhit=0 for 3 cycles, then dhit=1 with ihit=0, then ihit=1 two cycles later.
  - Required: freeze throughout the wait; dload_capture=1 on the dhit cycle; mem_done=1 and dreq_mask=1 for the next two cycles; adv on the ihit cycle; mem_done 0 afterward; stall_cycles=6.
- Halt:
  - Stimulus: exm_halt=1 with adv=1.
  - Required: halted=1 from next cycle; enables 0 regardless of ihit/dhit.
  - Assert RST for 1 cycle → halted=0, counters=0.
- Saturation:
  - Stimulus: force stall_cycles to 0xFFFFFFFE, then hold ihit=0 for 3 cycles.
  - Required: stall_cycles reads 0xFFFFFFFF and stays there.
